// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  localparam logic [2:0]  WIDTH_WORD         = 3'b010;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 64;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter for the arbiter; pulses timeout_o when memory never answers.
// Only present when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic busy_i,
  input  logic ready_i,
  output logic timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Counter is cleared in every non-busy cycle, so each BUSY entry starts at 0.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)  cnt_q <= '0;
    else if (busy_i) cnt_q <= cnt_q + CNT_W'(1);
    else             cnt_q <= '0;
  end

  assign timeout_o = busy_i & ~ready_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between fetch and data stages, data first.
// Optional watchdog/err_o built only when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_flush_i,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  input  logic [2:0]        dm_width_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [2:0]        mem_width_o,
  input  logic              mem_ready_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              stall_if_o,
  output logic              stall_dm_o,
  output logic              err_o
);

  arb_state_t state_q, state_d;
  logic       eff_if, eff_dm;
  logic       grant_if, grant_dm, done;
  logic       timeout;
  logic       flush_pend_q;

  always_comb begin
    eff_dm = dm_req_i & ~dm_valid_o;
    eff_if = if_req_i & ~if_valid_o & ~if_flush_i;
    // Gated by reset so stalls drop as soon as reset asserts.
    stall_dm_o = reset_n_i & eff_dm;
    stall_if_o = reset_n_i & eff_if;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    grant_if = 1'b0;
    grant_dm = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (eff_dm) begin
          grant_dm = 1'b1;
          state_d  = BUSY_DM;
        end else if (eff_if) begin
          grant_if = 1'b1;
          state_d  = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready_i || timeout) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_width_o  <= '0;
      if_rdata_o   <= '0;
      if_valid_o   <= 1'b0;
      dm_rdata_o   <= '0;
      dm_valid_o   <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      if_valid_o <= 1'b0;
      dm_valid_o <= 1'b0;

      if (grant_dm) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= dm_we_i;
        mem_addr_o  <= dm_addr_i;
        mem_wdata_o <= dm_wdata_i;
        mem_width_o <= dm_width_i;
      end else if (grant_if) begin
        mem_req_o   <= 1'b1;
        mem_we_o    <= 1'b0;
        mem_addr_o  <= if_addr_i;
        mem_wdata_o <= '0;
        mem_width_o <= WIDTH_WORD;
      end

      if (done) begin
        mem_req_o <= 1'b0;
        if (state_q == BUSY_DM) begin
          dm_valid_o <= 1'b1;
          if (timeout)        dm_rdata_o <= '0;
          else if (!mem_we_o) dm_rdata_o <= mem_rdata_i;
        end else if (!flush_pend_q && !if_flush_i) begin
          if_valid_o <= 1'b1;
          if_rdata_o <= timeout ? '0 : mem_rdata_i;
        end
      end

      // A redirect seen at any point of a fetch discards that fetch's result.
      flush_pend_q <= (state_q == BUSY_IF) & ~done & (flush_pend_q | if_flush_i);
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q;

  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .busy_i    (state_q != IDLE),
    .ready_i   (mem_ready_i),
    .timeout_o (timeout)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   err_q <= 1'b0;
    else if (timeout) err_q <= 1'b1;
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; timeout case runs when
// MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic              if_req_i, if_flush_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              dm_req_i, dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [2:0]        dm_width_i;
  logic              mem_req_o, mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [2:0]        mem_width_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic [DATA_W-1:0] if_rdata_o, dm_rdata_o;
  logic              if_valid_o, dm_valid_o;
  logic              stall_if_o, stall_dm_o, err_o;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_flush_i  (if_flush_i),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_width_i  (dm_width_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_width_o (mem_width_o),
    .mem_ready_i (mem_ready_i),
    .mem_rdata_i (mem_rdata_i),
    .if_rdata_o  (if_rdata_o),
    .if_valid_o  (if_valid_o),
    .dm_rdata_o  (dm_rdata_o),
    .dm_valid_o  (dm_valid_o),
    .stall_if_o  (stall_if_o),
    .stall_dm_o  (stall_dm_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle; inputs are driven at posedge+1, checks follow at posedge+2.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0; if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = '0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    dm_width_i = 3'b010; mem_ready_i = 1'b0; mem_rdata_i = '0;

    // Reset state
    repeat (3) @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    tick(); settle();
    check("rst_mem_req", mem_req_o, 0);
    check("rst_if_valid", if_valid_o, 0);
    check("rst_dm_valid", dm_valid_o, 0);
    check("rst_err", err_o, 0);

    // Single fetch, zero wait states
    tick(); if_req_i = 1'b1; if_addr_i = 32'h100; settle();
    check("f1_stall_t", stall_if_o, 1);
    check("f1_req_t", mem_req_o, 0);
    tick(); mem_ready_i = 1'b1; mem_rdata_i = 32'h00500093; settle();
    check("f1_req_t1", mem_req_o, 1);
    check("f1_addr", mem_addr_o, 32'h100);
    check("f1_we", mem_we_o, 0);
    check("f1_width", mem_width_o, 3'b010);
    check("f1_stall_t1", stall_if_o, 1);
    tick(); mem_ready_i = 1'b0; settle();
    check("f1_valid", if_valid_o, 1);
    check("f1_rdata", if_rdata_o, 32'h00500093);
    check("f1_stall_t2", stall_if_o, 0);
    check("f1_req_t2", mem_req_o, 0);
    tick(); if_req_i = 1'b0; settle();
    check("f1_no_regrant", mem_req_o, 0);
    check("f1_valid_once", if_valid_o, 0);
    check("f1_rdata_hold", if_rdata_o, 32'h00500093);

    // Contention: data load first, 3 wait states, then fetch
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h104;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h2000; dm_width_i = 3'b010;
    settle();
    check("c_stall_dm_t", stall_dm_o, 1);
    check("c_stall_if_t", stall_if_o, 1);
    for (int i = 1; i <= 3; i++) begin
      tick(); settle();
      check("c_req_busy", mem_req_o, 1);
      check("c_addr_dm", mem_addr_o, 32'h2000);
      check("c_stall_if_busy", stall_if_o, 1);
    end
    tick(); mem_ready_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; settle();
    check("c_addr_t4", mem_addr_o, 32'h2000);
    tick(); mem_ready_i = 1'b0; settle();
    check("c_dm_valid_t5", dm_valid_o, 1);
    check("c_dm_rdata", dm_rdata_o, 32'hDEADBEEF);
    check("c_req_t5", mem_req_o, 0);
    check("c_stall_dm_t5", stall_dm_o, 0);
    check("c_stall_if_t5", stall_if_o, 1);
    check("c_if_valid_t5", if_valid_o, 0);
    tick(); dm_req_i = 1'b0; mem_ready_i = 1'b1; mem_rdata_i = 32'hCAFE0013; settle();
    check("c_if_req_t6", mem_req_o, 1);
    check("c_if_addr_t6", mem_addr_o, 32'h104);
    check("c_dm_valid_t6", dm_valid_o, 0);
    tick(); mem_ready_i = 1'b0; settle();
    check("c_if_valid_t7", if_valid_o, 1);
    check("c_if_rdata", if_rdata_o, 32'hCAFE0013);
    tick(); if_req_i = 1'b0; settle();

    // Store with 2 wait states
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h40;
    dm_wdata_i = 32'h12345678; dm_width_i = 3'b000;
    settle();
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) begin mem_ready_i = 1'b1; mem_rdata_i = 32'hFFFFFFFF; end
      settle();
      check("s_req", mem_req_o, 1);
      check("s_we", mem_we_o, 1);
      check("s_width", mem_width_o, 3'b000);
      check("s_addr", mem_addr_o, 32'h40);
      check("s_wdata", mem_wdata_o, 32'h12345678);
    end
    tick(); mem_ready_i = 1'b0; settle();
    check("s_dm_valid", dm_valid_o, 1);
    check("s_dm_rdata_hold", dm_rdata_o, 32'hDEADBEEF);
    tick(); dm_req_i = 1'b0; dm_we_i = 1'b0; settle();
    check("s_dm_valid_once", dm_valid_o, 0);

    // Flush in IDLE blocks the fetch grant for that cycle
    tick(); if_req_i = 1'b1; if_addr_i = 32'h400; if_flush_i = 1'b1; settle();
    check("fi_stall", stall_if_o, 0);
    tick(); if_flush_i = 1'b0; settle();
    check("fi_blocked", mem_req_o, 0);
    tick(); mem_ready_i = 1'b1; mem_rdata_i = 32'h22222222; settle();
    check("fi_granted", mem_req_o, 1);
    check("fi_addr", mem_addr_o, 32'h400);
    tick(); mem_ready_i = 1'b0; settle();
    check("fi_valid", if_valid_o, 1);
    check("fi_rdata", if_rdata_o, 32'h22222222);
    tick(); if_req_i = 1'b0; settle();

    // Flush during BUSY_IF, 2 wait states
    tick(); if_req_i = 1'b1; if_addr_i = 32'h200; settle();
    tick(); if_flush_i = 1'b1; if_addr_i = 32'h300; settle();
    check("fb_req", mem_req_o, 1);
    check("fb_addr", mem_addr_o, 32'h200);
    check("fb_stall_flush", stall_if_o, 0);
    tick(); if_flush_i = 1'b0; settle();
    tick(); mem_ready_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0; settle();
    tick(); mem_ready_i = 1'b0; settle();
    check("fb_no_valid", if_valid_o, 0);
    check("fb_rdata_hold", if_rdata_o, 32'h22222222);
    check("fb_req_idle", mem_req_o, 0);
    tick(); mem_ready_i = 1'b1; mem_rdata_i = 32'h11111111; settle();
    check("fb_regrant", mem_req_o, 1);
    check("fb_new_addr", mem_addr_o, 32'h300);
    tick(); mem_ready_i = 1'b0; settle();
    check("fb_valid", if_valid_o, 1);
    check("fb_rdata", if_rdata_o, 32'h11111111);
    tick(); if_req_i = 1'b0; settle();

    // Async reset during BUSY_DM
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h80; dm_width_i = 3'b010;
    if_req_i = 1'b1; if_addr_i = 32'h500;
    settle();
    tick(); settle();
    check("r_busy_req", mem_req_o, 1);
    #2 reset_n_i = 1'b0;
    #1;
    check("r_mem_req", mem_req_o, 0);
    check("r_mem_addr", mem_addr_o, 0);
    check("r_stall_if", stall_if_o, 0);
    check("r_stall_dm", stall_dm_o, 0);
    check("r_if_valid", if_valid_o, 0);
    check("r_dm_valid", dm_valid_o, 0);
    check("r_dm_rdata", dm_rdata_o, 0);
    if_req_i = 1'b0; dm_req_i = 1'b0;
    @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    tick(); settle();
    check("r_idle_req", mem_req_o, 0);
    tick(); dm_req_i = 1'b1; dm_addr_i = 32'h84; settle();
    tick(); mem_ready_i = 1'b1; mem_rdata_i = 32'h33; settle();
    check("r_after_req", mem_req_o, 1);
    check("r_after_addr", mem_addr_o, 32'h84);
    tick(); mem_ready_i = 1'b0; settle();
    check("r_after_valid", dm_valid_o, 1);
    check("r_after_rdata", dm_rdata_o, 32'h33);
    tick(); dm_req_i = 1'b0; settle();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never ready: watchdog fires after 8 busy cycles
    tick(); dm_req_i = 1'b1; dm_addr_i = 32'h90; settle();
    for (int i = 1; i <= 8; i++) begin
      tick(); settle();
      check("t_busy_req", mem_req_o, 1);
      check("t_err_low", err_o, 0);
    end
    tick(); settle();
    check("t_err", err_o, 1);
    check("t_dm_valid", dm_valid_o, 1);
    check("t_dm_rdata", dm_rdata_o, 0);
    check("t_req_drop", mem_req_o, 0);
    tick(); dm_req_i = 1'b0; settle();
    check("t_err_sticky", err_o, 1);
    check("t_idle_req", mem_req_o, 0);
`else
    check("err_tied", err_o, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
